// File: rtl/cpu_nic_pkg.sv
// Shared constants for the CPU network interface controller.
package cpu_nic_pkg;

   // Default packet / CPU data width.
   localparam int NIC_DATA_WIDTH = 64;

   // Position of the virtual-channel bit in a packet (big-endian numbering).
   localparam int NIC_VC_BIT = 0;

   // CPU-visible register map.
   localparam logic [0:1] NIC_ADDR_OUT_BUF  = 2'b00;
   localparam logic [0:1] NIC_ADDR_OUT_STAT = 2'b01;
   localparam logic [0:1] NIC_ADDR_IN_BUF   = 2'b10;
   localparam logic [0:1] NIC_ADDR_IN_STAT  = 2'b11;

endpackage

// File: rtl/nic_channel_buffer.sv
// One-entry packet buffer with a full flag. Load wins over clear so a
// packet arriving in the same cycle as a clear is never lost.
module nic_channel_buffer
   import cpu_nic_pkg::*;
#(
   parameter int DATA_WIDTH = NIC_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [0:DATA_WIDTH-1] load_data,
   input  logic                  clear,
   output logic                  full,
   output logic [0:DATA_WIDTH-1] data
);

   logic                  full_q, full_d;
   logic [0:DATA_WIDTH-1] data_q, data_d;

   // Next-state: capture on load, drop the full flag on clear.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (load) begin
         full_d = 1'b1;
         data_d = load_data;
      end else if (clear) begin
         full_d = 1'b0;
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign full = full_q;
   assign data = data_q;

endmodule

// File: rtl/cpu_nic.sv
// CPU <-> mesh router NIC: register-mapped output/input channel buffers,
// valid/ready router handshake gated by virtual-channel polarity.
module cpu_nic
   import cpu_nic_pkg::*;
#(
   parameter int DATA_WIDTH = NIC_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  nicEn,
   input  logic                  nicWrEn,
   input  logic [0:1]            addr,
   input  logic [0:DATA_WIDTH-1] d_in,
   output logic [0:DATA_WIDTH-1] d_out,
   output logic                  net_so,
   input  logic                  net_ro,
   output logic [0:DATA_WIDTH-1] net_do,
   input  logic                  net_polarity,
   input  logic                  net_si,
   output logic                  net_ri,
   input  logic [0:DATA_WIDTH-1] net_di
);

   logic                  out_full, in_full;
   logic [0:DATA_WIDTH-1] out_buf, in_buf;
   logic                  cpu_wr, cpu_rd;
   logic                  out_load, in_load, in_clear;
   logic [0:DATA_WIDTH-1] d_out_q, d_out_d;

   assign cpu_wr = nicEn & nicWrEn;
   assign cpu_rd = nicEn & ~nicWrEn;

   // A write to a full out buffer is dropped even if it drains this cycle.
   assign out_load = cpu_wr & (addr == NIC_ADDR_OUT_BUF) & ~out_full;

   // Send only when the packet's VC bit matches the router's current phase.
   assign net_so = out_full & net_ro & (out_buf[NIC_VC_BIT] == net_polarity);
   assign net_do = out_buf;

   // Ready depends only on buffer state, never on this cycle's CPU access.
   assign net_ri   = ~in_full;
   assign in_load  = net_si & net_ri;
   assign in_clear = cpu_rd & (addr == NIC_ADDR_IN_BUF);

   nic_channel_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_out_chan (
      .clk       (clk),
      .reset     (reset),
      .load      (out_load),
      .load_data (d_in),
      .clear     (net_so),
      .full      (out_full),
      .data      (out_buf)
   );

   nic_channel_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_in_chan (
      .clk       (clk),
      .reset     (reset),
      .load      (in_load),
      .load_data (net_di),
      .clear     (in_clear),
      .full      (in_full),
      .data      (in_buf)
   );

   // CPU read mux; d_out holds its value when there is no read.
   always_comb begin
      d_out_d = d_out_q;
      if (cpu_rd) begin
         unique case (addr)
            NIC_ADDR_OUT_BUF:  d_out_d = '0;
            NIC_ADDR_OUT_STAT: d_out_d = {{(DATA_WIDTH-1){1'b0}}, out_full};
            NIC_ADDR_IN_BUF:   d_out_d = in_buf;
            NIC_ADDR_IN_STAT:  d_out_d = {{(DATA_WIDTH-1){1'b0}}, in_full};
            default:           d_out_d = d_out_q;
         endcase
      end
   end

   // Registered read data.
   always_ff @(posedge clk) begin
      if (!reset) d_out_q <= '0;
      else        d_out_q <= d_out_d;
   end

   assign d_out = d_out_q;

endmodule

// File: tb/tb_cpu_nic.sv
// Directed self-checking bench for cpu_nic.
module tb_cpu_nic;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          nicEn, nicWrEn;
   logic [0:1]    addr;
   logic [0:W-1]  d_in, d_out;
   logic          net_so, net_ro;
   logic [0:W-1]  net_do;
   logic          net_polarity, net_si, net_ri;
   logic [0:W-1]  net_di;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cpu_nic #(.DATA_WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .nicEn        (nicEn),
      .nicWrEn      (nicWrEn),
      .addr         (addr),
      .d_in         (d_in),
      .d_out        (d_out),
      .net_so       (net_so),
      .net_ro       (net_ro),
      .net_do       (net_do),
      .net_polarity (net_polarity),
      .net_si       (net_si),
      .net_ri       (net_ri),
      .net_di       (net_di)
   );

   // Advance past one rising edge; outputs are then sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [0:W-1] obs, input logic [0:W-1] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One-cycle CPU write.
   task automatic cpu_write(input logic [0:1] a, input logic [0:W-1] v);
      nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = v;
      step();
      nicEn = 1'b0; nicWrEn = 1'b0; d_in = '0;
   endtask

   // One-cycle CPU read; d_out is valid on return.
   task automatic cpu_read(input logic [0:1] a);
      nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
      step();
      nicEn = 1'b0;
   endtask

   initial begin
      reset = 1'b0; nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00; d_in = '0;
      net_ro = 1'b0; net_polarity = 1'b0; net_si = 1'b0; net_di = '0;

      // Reset state
      step(); step();
      check("rst_d_out",  d_out, '0);
      check("rst_net_so", W'(net_so), '0);
      check("rst_net_do", net_do, '0);
      check("rst_net_ri", W'(net_ri), W'(1));
      reset = 1'b1;
      cpu_read(2'b01); check("idle_out_stat", d_out, '0);
      cpu_read(2'b11); check("idle_in_stat",  d_out, '0);

      // Send with matching polarity
      net_polarity = 1'b0; net_ro = 1'b1;
      cpu_write(2'b00, 64'h0123_4567_89AB_CDEF);
      check("send_so",  W'(net_so), W'(1));
      check("send_do",  net_do, 64'h0123_4567_89AB_CDEF);
      step();
      check("send_so_fall", W'(net_so), '0);
      cpu_read(2'b01); check("send_out_stat", d_out, '0);

      // Polarity mismatch for 5 cycles, with a dropped write and a status read
      cpu_write(2'b00, 64'h8000_0000_0000_0001);
      check("pol_wait0", W'(net_so), '0);
      cpu_write(2'b00, 64'h0000_0000_0000_0002);   // dropped: buffer full
      check("pol_wait1", W'(net_so), '0);
      cpu_read(2'b01);
      check("pol_wait2", W'(net_so), '0);
      check("pol_out_stat", d_out, W'(1));
      step(); check("pol_wait3", W'(net_so), '0);
      step(); check("pol_wait4", W'(net_so), '0);
      // Polarity matches but router not ready
      net_ro = 1'b0; net_polarity = 1'b1; #1;
      check("bp_so", W'(net_so), '0);
      net_ro = 1'b1; #1;
      check("pol_so", W'(net_so), W'(1));
      check("pol_do", net_do, 64'h8000_0000_0000_0001);
      step();
      check("pol_so_fall", W'(net_so), '0);
      cpu_read(2'b01); check("pol_out_stat_clr", d_out, '0);

      // Receive
      check("rx_ri_idle", W'(net_ri), W'(1));
      net_si = 1'b1; net_di = 64'hDEAD_BEEF_0000_0042;
      step();
      net_si = 1'b0; net_di = '0;
      check("rx_ri_low", W'(net_ri), '0);
      cpu_read(2'b11); check("rx_in_stat", d_out, W'(1));

      // Second packet while full is not captured
      net_si = 1'b1; net_di = 64'h0000_0000_0000_0001;
      step();
      net_si = 1'b0; net_di = '0;
      check("rx_full_ri", W'(net_ri), '0);
      cpu_read(2'b10);
      check("rx_in_buf", d_out, 64'hDEAD_BEEF_0000_0042);
      check("rx_ri_back", W'(net_ri), W'(1));
      cpu_read(2'b11); check("rx_in_stat_clr", d_out, '0);

      // Fill both buffers, then reset mid-operation
      net_si = 1'b1; net_di = 64'h0000_0000_0000_0005;
      step();
      net_si = 1'b0; net_di = '0;
      check("mid_in_full", W'(net_ri), '0);
      net_ro = 1'b0; net_polarity = 1'b0;
      cpu_write(2'b00, 64'h0123_4567_89AB_CDEF);
      cpu_read(2'b01); check("mid_out_full", d_out, W'(1));
      net_ro = 1'b1; reset = 1'b0;
      step();
      reset = 1'b1;
      check("mrst_so",    W'(net_so), '0);
      check("mrst_do",    net_do, '0);
      check("mrst_ri",    W'(net_ri), W'(1));
      check("mrst_d_out", d_out, '0);
      cpu_read(2'b01); check("mrst_out_stat", d_out, '0);
      cpu_read(2'b11); check("mrst_in_stat",  d_out, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
